// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall encodings, exception
// codes, FSM state encoding and bus widths.
package pipe_ctrl_pkg;

    localparam int EXCEPT_BUS_W = 32;
    localparam int REG_BUS_W    = 32;
    localparam int STALL_W      = 6;

    // Each encoding freezes the PC plus every register up to the requesting stage.
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    localparam logic [EXCEPT_BUS_W-1:0] EXC_INT          = 32'h0000_0001;
    localparam logic [EXCEPT_BUS_W-1:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [EXCEPT_BUS_W-1:0] EXC_INST_INVALID = 32'h0000_000A;
    localparam logic [EXCEPT_BUS_W-1:0] EXC_OV           = 32'h0000_000C;
    localparam logic [EXCEPT_BUS_W-1:0] EXC_TRAP         = 32'h0000_000D;
    localparam logic [EXCEPT_BUS_W-1:0] EXC_ERET         = 32'h0000_000E;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MTC0_WAIT = 2'd1,
        ST_FLUSHED   = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl_vec.sv
// Exception decode to redirect PC: EPC for ERET, the common handler vector
// for every other nonzero code, zero when no exception is pending.
module pipe_ctrl_vec
    import pipe_ctrl_pkg::*;
#(
    parameter logic [REG_BUS_W-1:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic [EXCEPT_BUS_W-1:0] excepttype_i,
    input  logic [REG_BUS_W-1:0]    cp0_epc_i,
    output logic [REG_BUS_W-1:0]    new_pc_o
);

    always_comb begin
        new_pc_o = '0;
        if (excepttype_i == EXC_ERET) begin
            new_pc_o = cp0_epc_i;
        end else if (excepttype_i != '0) begin
            new_pc_o = EXC_VECTOR;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall arbitration, exception flush/redirect and MTC0
// hazard bubbles. Optional perf counters under PIPE_CTRL_PERF_CNT_EN.
//
// state        | meaning
// ST_IDLE      | normal flow, arbitrating stage stall requests
// ST_MTC0_WAIT | inserting CP0 bubbles behind an MTC0 held in ID
// ST_FLUSHED   | cycle after a flush; ID/IF requests and MTC0 are stale
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                   MTC0_BUBBLES = 2,
    parameter logic [REG_BUS_W-1:0] EXC_VECTOR   = 32'h0000_0020
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stallreq_if_i,
    input  logic                    stallreq_id_i,
    input  logic                    stallreq_ex_i,
    input  logic                    stallreq_mem_i,
    input  logic                    mtc0_in_id_i,
    input  logic [EXCEPT_BUS_W-1:0] excepttype_i,
    input  logic [REG_BUS_W-1:0]    cp0_epc_i,
    output logic [STALL_W-1:0]      stall_o,
    output logic                    flush_o,
    output logic [REG_BUS_W-1:0]    new_pc_o,
    output logic [1:0]              mtc0_cnt_o
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]             stall_cycles_o,
    output logic [15:0]             flush_count_o
`endif
);

    localparam logic [1:0] BUBBLES = 2'(MTC0_BUBBLES);

    state_t               state, state_nxt;
    logic [1:0]           cnt, cnt_nxt;
    logic [STALL_W-1:0]   req_stall, stall;
    logic                 flush, exc;
    logic [REG_BUS_W-1:0] vec_pc;

    assign exc = (excepttype_i != '0);

    always_comb begin
        req_stall = STALL_NONE;
        if (stallreq_mem_i)     req_stall = STALL_MEM;
        else if (stallreq_ex_i) req_stall = STALL_EX;
        else if (stallreq_id_i) req_stall = STALL_ID;
        else if (stallreq_if_i) req_stall = STALL_IF;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = STALL_NONE;
        flush     = 1'b0;
        if (exc) begin
            flush     = 1'b1;
            state_nxt = ST_FLUSHED;
            cnt_nxt   = 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_stall != STALL_NONE) begin
                        stall = req_stall;
                    end else if (mtc0_in_id_i) begin
                        stall     = STALL_ID;
                        state_nxt = ST_MTC0_WAIT;
                        cnt_nxt   = 2'd1;
                    end
                end
                ST_MTC0_WAIT: begin
                    // A competing stall holds the count; the bubble resumes afterwards.
                    if (req_stall != STALL_NONE) begin
                        stall = req_stall;
                    end else if (cnt < BUBBLES) begin
                        stall   = STALL_ID;
                        cnt_nxt = cnt + 2'd1;
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = 2'd0;
                    end
                end
                ST_FLUSHED: begin
                    state_nxt = ST_IDLE;
                    if (stallreq_mem_i)     stall = STALL_MEM;
                    else if (stallreq_ex_i) stall = STALL_EX;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    pipe_ctrl_vec #(.EXC_VECTOR(EXC_VECTOR)) u_vec (
        .excepttype_i (excepttype_i),
        .cp0_epc_i    (cp0_epc_i),
        .new_pc_o     (vec_pc)
    );

    assign stall_o    = rst ? STALL_NONE : stall;
    assign flush_o    = rst ? 1'b0 : flush;
    assign new_pc_o   = rst ? '0 : vec_pc;
    assign mtc0_cnt_o = (!rst && state == ST_MTC0_WAIT) ? cnt : 2'd0;

`ifdef PIPE_CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_o <= '0;
            flush_count_o  <= '0;
        end else begin
            if (stall_o != STALL_NONE) stall_cycles_o <= stall_cycles_o + 32'd1;
            if (flush_o)               flush_count_o  <= flush_count_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle compare against a behavioural model
// plus hand-computed literal checks of the main scenarios.
module tb_pipe_ctrl;

    localparam int B = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_if = 1'b0, s_id = 1'b0, s_ex = 1'b0, s_mem = 1'b0, mtc0 = 1'b0;
    logic [31:0] exc = '0, epc = '0;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [1:0]  mtc0_cnt_o;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int n_vec = 0;
    int n_err = 0;
    bit started = 1'b0;

    pipe_ctrl #(.MTC0_BUBBLES(B), .EXC_VECTOR(32'h20)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_if_i  (s_if),
        .stallreq_id_i  (s_id),
        .stallreq_ex_i  (s_ex),
        .stallreq_mem_i (s_mem),
        .mtc0_in_id_i   (mtc0),
        .excepttype_i   (exc),
        .cp0_epc_i      (epc),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .new_pc_o       (new_pc_o),
        .mtc0_cnt_o     (mtc0_cnt_o)
`ifdef PIPE_CTRL_PERF_CNT_EN
        ,
        .stall_cycles_o (stall_cycles),
        .flush_count_o  (flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a stall freezes the first n pipeline registers, mask = 2^n - 1.
    int  m_seq    = 0;
    int  m_issued = 0;
    int  m_flushed = 0;
    int  m_stalls = 0;
    int  m_flushes = 0;

    always @(negedge clk) begin
        int          n;
        int          e_cnt;
        logic        e_flush;
        logic [31:0] e_pc;
        if (started) begin
            n = 0; e_flush = 1'b0; e_pc = '0; e_cnt = 0;
            if (rst) begin
                m_seq = 0; m_issued = 0; m_flushed = 0;
            end else begin
                e_cnt = m_seq ? m_issued : 0;
                if (exc != 0) begin
                    e_flush = 1'b1;
                    e_pc = (exc == 32'hE) ? epc : 32'h20;
                    m_seq = 0; m_issued = 0; m_flushed = 1;
                end else if (m_flushed != 0) begin
                    n = s_mem ? 5 : s_ex ? 4 : 0;
                    m_flushed = 0;
                end else begin
                    n = s_mem ? 5 : s_ex ? 4 : s_id ? 3 : s_if ? 2 : 0;
                    if (n == 0) begin
                        if (m_seq != 0) begin
                            if (m_issued < B) begin n = 3; m_issued++; end
                            else begin m_seq = 0; m_issued = 0; end
                        end else if (mtc0) begin
                            n = 3; m_seq = 1; m_issued = 1;
                        end
                    end
                end
            end
            chk("stall", {26'd0, stall_o}, (32'd1 << n) - 32'd1);
            chk("flush", {31'd0, flush_o}, {31'd0, e_flush});
            chk("new_pc", new_pc_o, e_pc);
            chk("mtc0_cnt", {30'd0, mtc0_cnt_o}, e_cnt);
`ifdef PIPE_CTRL_PERF_CNT_EN
            if (!rst) begin
                chk("stall_cycles", stall_cycles, m_stalls);
                chk("flush_count", {16'd0, flush_count}, m_flushes & 32'hFFFF);
            end
            if (rst) begin m_stalls = 0; m_flushes = 0; end
            else begin
                if (n != 0) m_stalls++;
                if (e_flush) m_flushes++;
            end
`endif
        end
    end

    // Drive one cycle: req = {mem, ex, id, if}; returns at the sampling negedge.
    task automatic cyc(input logic r, input logic [3:0] req, input logic m,
                       input logic [31:0] e, input logic [31:0] p);
        @(posedge clk);
        #1;
        rst = r; {s_mem, s_ex, s_id, s_if} = req; mtc0 = m; exc = e; epc = p;
        started = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset masks exception and MTC0
        cyc(1, 4'b0000, 1, 32'h8, 32'h55);
        chk("rst_stall", {26'd0, stall_o}, 32'h0);
        chk("rst_flush", {31'd0, flush_o}, 32'h0);
        chk("rst_pc", new_pc_o, 32'h0);
        chk("rst_cnt", {30'd0, mtc0_cnt_o}, 32'h0);
        cyc(0, 4'b0000, 0, 0, 0);
        chk("idle_stall", {26'd0, stall_o}, 32'h0);

        // MTC0 bubbles
        cyc(0, 4'b0000, 1, 0, 0);
        chk("mtc0_s0", {26'd0, stall_o}, 32'h07); chk("mtc0_c0", {30'd0, mtc0_cnt_o}, 32'd0);
        cyc(0, 4'b0000, 1, 0, 0);
        chk("mtc0_s1", {26'd0, stall_o}, 32'h07); chk("mtc0_c1", {30'd0, mtc0_cnt_o}, 32'd1);
        cyc(0, 4'b0000, 1, 0, 0);
        chk("mtc0_s2", {26'd0, stall_o}, 32'h00); chk("mtc0_c2", {30'd0, mtc0_cnt_o}, 32'd2);
        cyc(0, 4'b0000, 0, 0, 0);
        chk("mtc0_done", {30'd0, mtc0_cnt_o}, 32'd0);

        // Priority ex over if
        cyc(0, 4'b0101, 0, 0, 0); chk("ex_if", {26'd0, stall_o}, 32'h0F);
        cyc(0, 4'b0001, 0, 0, 0); chk("if_only", {26'd0, stall_o}, 32'h03);
        cyc(0, 4'b0010, 0, 0, 0); chk("id_only", {26'd0, stall_o}, 32'h07);
        cyc(0, 4'b1111, 0, 0, 0); chk("mem_all", {26'd0, stall_o}, 32'h1F);
        cyc(0, 4'b0000, 0, 0, 0); chk("none", {26'd0, stall_o}, 32'h00);

        // Syscall beats mem; stale ID request ignored next cycle
        cyc(0, 4'b1000, 0, 32'h8, 32'h99);
        chk("exc_flush", {31'd0, flush_o}, 32'h1);
        chk("exc_stall", {26'd0, stall_o}, 32'h0);
        chk("exc_pc", new_pc_o, 32'h20);
        cyc(0, 4'b0010, 1, 0, 0); chk("stale_id", {26'd0, stall_o}, 32'h0);
        cyc(0, 4'b0010, 0, 0, 0); chk("id_after", {26'd0, stall_o}, 32'h07);

        // ERET and other codes
        cyc(0, 4'b0000, 0, 32'hE, 32'h1234); chk("eret_pc", new_pc_o, 32'h1234);
        cyc(0, 4'b0100, 0, 0, 0); chk("flushed_ex", {26'd0, stall_o}, 32'h0F);
        cyc(0, 4'b0000, 0, 32'h1, 32'h1234); chk("int_pc", new_pc_o, 32'h20);
        cyc(0, 4'b0000, 0, 32'hD, 32'h1234);
        cyc(0, 4'b1000, 0, 0, 0); chk("flushed_mem", {26'd0, stall_o}, 32'h1F);
        cyc(0, 4'b0000, 0, 32'hA, 0);
        cyc(0, 4'b0000, 0, 32'hC, 0); chk("ov_again", {31'd0, flush_o}, 32'h1);
        cyc(0, 4'b0000, 0, 0, 0);

        // MTC0 interrupted by mem stall
        cyc(0, 4'b0000, 1, 0, 0);
        cyc(0, 4'b1000, 1, 0, 0);
        chk("frz_s0", {26'd0, stall_o}, 32'h1F); chk("frz_c0", {30'd0, mtc0_cnt_o}, 32'd1);
        cyc(0, 4'b1000, 1, 0, 0);
        chk("frz_s1", {26'd0, stall_o}, 32'h1F); chk("frz_c1", {30'd0, mtc0_cnt_o}, 32'd1);
        cyc(0, 4'b0000, 1, 0, 0); chk("frz_bub", {26'd0, stall_o}, 32'h07);
        cyc(0, 4'b0000, 1, 0, 0); chk("frz_rel", {26'd0, stall_o}, 32'h00);
        cyc(0, 4'b0000, 0, 0, 0);

        // Exception mid-sequence, and exception together with MTC0 in IDLE
        cyc(0, 4'b0000, 1, 0, 0);
        cyc(0, 4'b0000, 1, 32'hA, 0); chk("exc_wait_cnt", {30'd0, mtc0_cnt_o}, 32'd1);
        cyc(0, 4'b0010, 1, 0, 0);
        cyc(0, 4'b0000, 1, 32'h1, 0); chk("exc_mtc0", {26'd0, stall_o}, 32'h0);
        cyc(0, 4'b0000, 1, 0, 0);
        cyc(0, 4'b0000, 1, 0, 0); chk("restart", {26'd0, stall_o}, 32'h07);

        // Reset mid-sequence aborts without a release cycle
        cyc(0, 4'b0000, 0, 0, 0);
        cyc(0, 4'b0000, 1, 0, 0);
        cyc(1, 4'b0000, 1, 0, 0); chk("rst_mid", {26'd0, stall_o}, 32'h0);
        cyc(0, 4'b0000, 0, 0, 0);
        chk("post_rst_stall", {26'd0, stall_o}, 32'h0);
        chk("post_rst_cnt", {30'd0, mtc0_cnt_o}, 32'd0);
`ifdef PIPE_CTRL_PERF_CNT_EN
        chk("post_rst_perf", stall_cycles, 32'd0);
`endif
        cyc(0, 4'b0000, 1, 0, 0);
        chk("post_rst_mtc0", {26'd0, stall_o}, 32'h07);
        chk("post_rst_c", {30'd0, mtc0_cnt_o}, 32'd0);
        cyc(0, 4'b0000, 0, 0, 0);
        cyc(0, 4'b0000, 0, 0, 0);
        cyc(0, 4'b0000, 0, 0, 0);

        started = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
